// File: rtl/iic_slave.sv
//-----------------------------------------------------------------------------
// iic_slave
//
// I2C slave front end for a byte-wide register file. The block answers to the
// 7-bit address DEV_ID. After the address byte, a write carries one word
// address byte followed by any number of data bytes. A read returns bytes
// starting at the current word address. The word address auto-increments
// and wraps from 8'hFF to 8'h00.
//
// scl_in and sda_in are asynchronous. Each passes through SYNC_STAGES flops,
// and the allowed range of SYNC_STAGES is 2..3. Edge detection and START/STOP
// detection compare the last two synchronized samples. The block changes
// sda_oe only on a synchronized SCL falling edge. The one exception is that
// START, STOP and reset release SDA.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   scl_in     bus SCL (asynchronous)
//   sda_in     bus SDA (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release (open-drain pad)
//   wp         write protect: NACK write data bytes and suppress reg_wr
//   reg_add    current word address
//   reg_wdata  received write data, valid while reg_wr = 1
//   reg_wr     one-clk write strobe
//   reg_rdata  read data for reg_add (combinational from the register file)
//   reg_rd     one-clk strobe when a read byte is loaded for transmission
//   busy       1 while this device is addressed, cleared by STOP
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module iic_slave #(
    parameter logic [6:0] DEV_ID      = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       wp,
    output logic [7:0] reg_add,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    input  logic [7:0] reg_rdata,
    output logic       reg_rd,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEVADDR  = 4'd1,
        ST_DEVACK   = 4'd2,
        ST_WORDADDR = 4'd3,
        ST_WORDACK  = 4'd4,
        ST_WDATA    = 4'd5,
        ST_WDATAACK = 4'd6,
        ST_RDATA    = 4'd7,
        ST_RDACK    = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;

    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    state_t     state_r;
    logic [3:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       sda_oe_r;
    logic       reg_wr_r;
    logic       reg_rd_r;
    logic       busy_r;
    logic [7:0] reg_add_r;
    logic [7:0] reg_wdata_r;
    logic       mack_r;

    // Bus synchronizers; they reset to the idle-high bus level so that reset release produces no false START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
            sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    // Bus event decode from the last two synchronized samples.
    always_comb begin
        scl_s      = scl_sync_r[SYNC_STAGES-1];
        sda_s      = sda_sync_r[SYNC_STAGES-1];
        scl_rise_s = scl_s & ~scl_prev_r;
        scl_fall_s = ~scl_s & scl_prev_r;
        start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
        stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    end

    // Protocol FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            sda_oe_r    <= 1'b0;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            reg_add_r   <= 8'h00;
            reg_wdata_r <= 8'h00;
            mack_r      <= 1'b0;
        end else begin
            reg_wr_r <= 1'b0;
            reg_rd_r <= 1'b0;
            if (start_s) begin
                state_r   <= ST_DEVADDR;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_IGNORE: begin
                        sda_oe_r <= 1'b0;
                    end
                    ST_DEVADDR: begin
                        if (scl_rise_s && bit_cnt_r != 4'd8) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[7:1] == DEV_ID) begin
                                state_r  <= ST_DEVACK;
                                sda_oe_r <= 1'b1;
                                busy_r   <= 1'b1;
                            end else begin
                                state_r  <= ST_IGNORE;
                                sda_oe_r <= 1'b0;
                                busy_r   <= 1'b0;
                            end
                        end
                    end
                    ST_DEVACK: begin
                        // shift_r still holds the address byte, so bit 0 is R/W.
                        if (scl_fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (shift_r[0]) begin
                                shift_r  <= reg_rdata;
                                sda_oe_r <= ~reg_rdata[7];
                                reg_rd_r <= 1'b1;
                                state_r  <= ST_RDATA;
                            end else begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_WORDADDR;
                            end
                        end
                    end
                    ST_WORDADDR: begin
                        if (scl_rise_s && bit_cnt_r != 4'd8) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            reg_add_r <= shift_r;
                            sda_oe_r  <= 1'b1;
                            state_r   <= ST_WORDACK;
                        end
                    end
                    ST_WORDACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r <= 1'b0;
                            state_r  <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise_s && bit_cnt_r != 4'd8) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_WDATAACK;
                            if (!wp) begin
                                reg_wdata_r <= shift_r;
                                reg_wr_r    <= 1'b1;
                                sda_oe_r    <= 1'b1;
                            end else begin
                                sda_oe_r    <= 1'b0;
                            end
                        end
                    end
                    ST_WDATAACK: begin
                        // sda_oe_r high here means this byte was ACKed.
                        if (scl_fall_s) begin
                            if (sda_oe_r) begin
                                reg_add_r <= reg_add_r + 8'd1;
                            end
                            sda_oe_r <= 1'b0;
                            state_r  <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise_s && bit_cnt_r != 4'd8) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
                            bit_cnt_r <= 4'd0;
                            sda_oe_r  <= 1'b0;
                            state_r   <= ST_RDACK;
                        end else if (scl_fall_s) begin
                            shift_r  <= {shift_r[6:0], 1'b0};
                            sda_oe_r <= ~shift_r[6];
                        end
                    end
                    ST_RDACK: begin
                        // Advance the address at the ACK sample so reg_rdata is settled by the SCL fall.
                        if (scl_rise_s) begin
                            mack_r <= ~sda_s;
                            if (!sda_s) begin
                                reg_add_r <= reg_add_r + 8'd1;
                            end
                        end else if (scl_fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (mack_r) begin
                                shift_r  <= reg_rdata;
                                sda_oe_r <= ~reg_rdata[7];
                                reg_rd_r <= 1'b1;
                                state_r  <= ST_RDATA;
                            end else begin
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_IGNORE;
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_r;
    assign reg_add   = reg_add_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_wr    = reg_wr_r;
    assign reg_rd    = reg_rd_r;
    assign busy      = busy_r;

endmodule

// File: doc/iic_slave.md
IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 Parameter DEV_ID, default 7'h50, is the 7-bit device address this block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth on scl_in and sda_in; allowed range 2..3.
REQ-003 clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 scl_in  input  1  bus SCL, asynchronous to clk.
REQ-006 sda_in  input  1  bus SDA, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release (pad is open-drain, external pull-up).
REQ-008 wp  input  1  write protect; 1 = NACK every write data byte and suppress reg_wr.
REQ-009 reg_add  output  8  current word address.
REQ-010 reg_wdata  output  8  received write data, valid while reg_wr=1.
REQ-011 reg_wr  output  1  one-clk write strobe.
REQ-012 reg_rdata  input  8  read data for reg_add; combinational, valid in the same cycle as reg_add.
REQ-013 reg_rd  output  1  one-clk strobe when a read byte is loaded for transmission.
REQ-014 busy  output  1  1 from START to STOP while addressed.

Function
REQ-015 scl_in and sda_in shall pass through SYNC_STAGES flops; edge detection shall compare the last two synchronized samples.
REQ-016 START: sync SDA falls while sync SCL is high. STOP: sync SDA rises while sync SCL is high. Both take effect in any state.
REQ-017 Bits are sampled on the SCL rising edge, MSB first.
REQ-018 sda_oe changes only on the SCL falling edge, never while SCL is high.
REQ-019 FSM states are IDLE, DEVADDR, DEVACK, WORDADDR, WORDACK, WDATA, WDATAACK, RDATA, RDACK, and IGNORE.
REQ-020 Entry: START or repeated START leads to DEVADDR with the bit counter cleared from any state.
REQ-021 DEVADDR: after 8 bits, if addr[7:1]==DEV_ID the FSM goes to DEVACK and drives sda_oe=1 for one SCL period; otherwise it goes to IGNORE with sda_oe=0.
REQ-022 DEVACK with R/W=0 goes to WORDADDR. DEVACK with R/W=1 goes to RDATA and loads reg_rdata into the shift register at the SCL fall ending the ACK, pulsing reg_rd.
REQ-023 WORDADDR: after 8 bits, update reg_add, ACK, then go to WDATA.
REQ-024 WDATA: after 8 bits, if wp=0 pulse reg_wr with reg_wdata for one clk and ACK. If wp=1, NACK and do not pulse reg_wr. Either way go to WDATAACK, then WDATA; a STOP or repeated START ends it.
REQ-025 After each ACKed write, reg_add increments with wrap 8'hFF->8'h00.
REQ-026 RDATA: shift the byte out on SDA (sda_oe = ~bit), then go to RDACK and release SDA.
REQ-027 RDACK: on master ACK (SDA low at SCL rise), increment reg_add, load the next byte and pulse reg_rd, then go to RDATA. On master NACK, go to IGNORE.
REQ-028 IGNORE: sda_oe=0 until START/STOP.
REQ-029 STOP leads to IDLE; sda_oe=0, busy=0, and reg_add is retained.
REQ-030 A repeated START after WORDACK keeps reg_add, so random read works as a write of the address followed by a restart read.
REQ-031 reg_wr and reg_rd shall never assert in the same clk.

Reset
REQ-032 On rst_n=0: state=IDLE; sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_add=8'h00, reg_wdata=8'h00, bit counter=0.
REQ-033 Reset mid-transfer releases SDA immediately; the block ignores the bus until the next START.
REQ-034 Between reset and the first START, the block shall not drive SDA.

Verification
REQ-035 Write: START, 0xA0, 0x12, 0x5A, STOP -> three ACKs; reg_wr pulse with reg_add=0x12 and reg_wdata=0x5A; then reg_add=0x13.
REQ-036 Random read: START, 0xA0, 0x40, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP, with reg_rdata=~reg_add -> bytes 0xBF and 0xBE; reg_rd pulses twice.
REQ-037 Address mismatch: START, 0xA2, ... -> no ACK; sda_oe=0 throughout; no reg_wr or reg_rd.
REQ-038 wp=1: START, 0xA0, 0x05, 0x77 -> ACK, ACK, NACK on the data byte; no reg_wr.
REQ-039 Wrap: write to address 0xFF with 2 data bytes -> reg_wr at 0xFF then at 0x00.
REQ-040 STOP inserted mid-byte in WDATA -> IDLE, no reg_wr, busy=0; the next transaction succeeds.
